// File: rtl/sqrt_pkg.sv
// Shared state codes for the square-root sequencer and its state-decode controller.
package sqrt_pkg;

  localparam int STATE_W = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_INIT   = 4'd2,
    S_DIV    = 4'd3,
    S_ADD    = 4'd4,
    S_HALF   = 4'd5,
    S_DIFF   = 4'd6,
    S_ABS    = 4'd7,
    S_CHECK  = 4'd8,
    S_UPD    = 4'd9,
    S_OUTPUT = 4'd10
  } state_t;

endpackage

// File: rtl/sqrt_sequencer_iter_counter.sv
// Saturating Newton-iteration counter with a terminal-count flag at MAX_ITER-1.
module iter_counter
  import sqrt_pkg::*;
#(
  parameter int MAX_ITER = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != SAT))
      count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/sqrt_sequencer.sv
// Newton-iteration square-root control sequencer; iteration limit enabled by ITER_LIMIT_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | waiting for operand (in_valid)
//   INIT   | seed the root estimate
//   DIV    | n / x
//   ADD    | x + n/x
//   HALF   | (x + n/x) / 2
//   DIFF   | root - x
//   ABS    | |root - x|
//   CHECK  | converged if |root - x| - I < 0 (alu_neg)
//   UPD    | x <= root, count iteration
//   OUTPUT | result held until out_ready
module sqrt_sequencer #(
  parameter int MAX_ITER = 16,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic               alu_neg,
  input  logic               out_ready,
  output logic [STATE_W-1:0] current_state,
  output logic               in_ready,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [7:0]         iter_count
);
  import sqrt_pkg::*;

`ifdef ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t state, nxt;
  logic   tc, limit_hit, launch;

  assign launch    = (state == S_IDLE) && start;
  assign limit_hit = LIMIT_EN && tc;

  iter_counter #(.MAX_ITER(MAX_ITER)) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .inc   (state == S_UPD),
    .count (iter_count),
    .tc    (tc)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_LOAD;
      S_LOAD:   if (in_valid) nxt = S_INIT;
      S_INIT:   nxt = S_DIV;
      S_DIV:    nxt = S_ADD;
      S_ADD:    nxt = S_HALF;
      S_HALF:   nxt = S_DIFF;
      S_DIFF:   nxt = S_ABS;
      S_ABS:    nxt = S_CHECK;
      S_CHECK:  nxt = (alu_neg || limit_hit) ? S_OUTPUT : S_UPD;
      S_UPD:    nxt = S_DIV;
      S_OUTPUT: if (out_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // timeout stays set through OUTPUT and IDLE until the next computation launches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == S_OUTPUT) && out_ready;
      if (launch)
        timeout <= 1'b0;
      else if ((state == S_CHECK) && !alu_neg && limit_hit)
        timeout <= 1'b1;
    end
  end

  assign current_state = STATE_W'(state);
  assign in_ready      = (state == S_LOAD);
  assign out_valid     = (state == S_OUTPUT);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Scoreboard bench for sqrt_sequencer: random convergence points, operand waits and back-pressure.
module tb_sqrt_sequencer;
  import sqrt_pkg::*;

  localparam int MAXI = 4;
`ifdef ITER_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, in_valid = 1'b0, alu_neg = 1'b0, out_ready = 1'b0;
  logic [3:0] current_state;
  logic       in_ready, out_valid, busy, done, timeout;
  logic [7:0] iter_count;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int accept;
    int iters;
    bit to;
  } exp_t;
  exp_t q[$];
  bit done_exp = 1'b0;
  bit seen = 1'b0;

  sqrt_sequencer #(.MAX_ITER(MAXI), .STATE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .alu_neg       (alu_neg),
    .out_ready     (out_ready),
    .current_state (current_state),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .iter_count    (iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // monitor: samples after the stimulus has driven the negedge inputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("done", done, done_exp);
        done_exp = 1'b0;
        if (out_valid) begin
          if (q.size() == 0) chk("sb_depth", q.size(), 1);
          else begin
            if (!seen) begin
              chk("latency", cyc - q[0].accept, 8 + 7 * q[0].iters);
              seen = 1'b1;
            end
            if (out_ready) begin
              e = q.pop_front();
              chk("iter_count", iter_count, e.iters);
              chk("timeout", timeout, e.to);
              done_exp = 1'b1;
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic launch_txn(input int w, output int c0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_state", current_state, 1);
    chk("load_in_ready", in_ready, 1);
    chk("load_iter_clr", iter_count, 0);
    chk("load_timeout_clr", timeout, 0);
    for (int i = 0; i < w; i++) begin
      start = 1'($urandom % 2);
      tick();
      start = 1'b0;
      chk("load_hold", current_state, 1);
    end
    in_valid = 1'b1;
    c0 = cyc;
  endtask

  task automatic run_txn(input int t);
    int k, w, c0, it, ovc, n;
    bit to, fin;
    exp_t e;
    k   = (t == 1) ? 5 : int'($urandom_range(0, 5));
    w   = (t == 0) ? 5 : int'($urandom_range(0, 3));
    ovc = 0;
    fin = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    launch_txn(w, c0);
    to = LIM && (k > MAXI - 1);
    it = to ? MAXI - 1 : k;
    e.accept = c0; e.iters = it; e.to = to;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("init_state", current_state, 2);
    for (int i = 0; i < 400 && !fin; i++) begin
      n = cyc - c0;
      alu_neg = (n == 7 + 7 * k);
      start   = (n >= 1 && n <= 6) ? 1'($urandom % 2) : 1'b0;
      if (t == 0) begin
        if (out_valid) begin
          ovc++;
          if (ovc <= 3) chk("bp_hold", current_state, 10);
        end
        out_ready = (ovc >= 4);
      end else
        out_ready = ($urandom % 3 == 0);
      tick();
      if (!busy) fin = 1'b1;
    end
    if (!fin) chk("txn_finished", 0, 1);
    alu_neg = 1'b0; start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic reset_mid_div();
    int c0;
    launch_txn(0, c0);
    tick();
    in_valid = 1'b0;
    while (cyc < c0 + 9) tick();
    chk("div2_state", current_state, 3);
    chk("div2_iter", iter_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state", current_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", current_state, 0);
  endtask

  task automatic illegal_state();
    tick();
    force dut.state = state_t'(4'd13);
    #1;
    chk("illegal_forced", current_state, 13);
    chk("illegal_busy", busy, 1);
    release dut.state;
    tick();
    chk("illegal_recover", current_state, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_state", current_state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_iter", iter_count, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) run_txn(t);
    reset_mid_div();
    illegal_state();
    for (int t = 12; t < 16; t++) run_txn(t);
    repeat (4) tick();
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish by time 500000");
    $fatal(1);
  end

endmodule
